// File: rtl/check_for_zood_pkg.sv
// Shared game definitions: shape code width, slot count, pattern width.
// Combinational helpers only, no state.
// Used by the comparator and the pattern loader.
package check_for_zood_pkg;

  localparam int SHAPE_W   = 3;
  localparam int NUM_SLOTS = 4;
  localparam int PATTERN_W = SHAPE_W * NUM_SLOTS;

  typedef logic [SHAPE_W-1:0] shape_t;

  // Slot i occupies bits [3i+2:3i]; slot 0 is the least significant.
  function automatic shape_t get_slot(input logic [PATTERN_W-1:0] pattern, input int idx);
    return pattern[idx*SHAPE_W +: SHAPE_W];
  endfunction

endpackage

// File: rtl/check_for_zood_if.sv
// Bundle between the game controller and the comparator.
// Carries pattern, guess, evaluate strobe and the held match mask.
// No flow control: a new check is accepted every cycle.
interface check_for_zood_if;
  import check_for_zood_pkg::*;

  logic [PATTERN_W-1:0] masterPattern;
  logic [PATTERN_W-1:0] guess;
  logic                 check;
  logic [NUM_SLOTS-1:0] Zood;

  modport master (
    output masterPattern,
    output guess,
    output check,
    input  Zood
  );

  modport slave (
    input  masterPattern,
    input  guess,
    input  check,
    output Zood
  );

endinterface

// File: rtl/check_for_zood_slot_compare.sv
// Exact equality of one guess shape against one master shape.
// Purely combinational, zero latency.
// No backpressure.
module check_for_zood_slot_compare
  import check_for_zood_pkg::*;
(
  input  shape_t guess_shape,
  input  shape_t master_shape,
  output logic   match
);

  // Literal compare: code 000 is an ordinary shape, not a wildcard.
  always_comb begin
    match = (guess_shape == master_shape);
  end

endmodule

// File: rtl/check_for_zood.sv
// Registered per-slot match mask of guess versus master pattern.
// Latency 1 cycle from a qualifying check edge to Zood.
// No backpressure; Zood holds until the next check or reset.
module check_for_zood
  import check_for_zood_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  check_for_zood_if.slave  bus
);

  logic [NUM_SLOTS-1:0] match_vec;

  // One comparator per slot; a shape in the wrong slot never earns credit.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    check_for_zood_slot_compare u_slot_compare (
      .guess_shape  (get_slot(bus.guess, i)),
      .master_shape (get_slot(bus.masterPattern, i)),
      .match        (match_vec[i])
    );
  end

  // Reset wins over check; otherwise capture on check and hold between checks.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.Zood <= '0;
    end else if (bus.check) begin
      bus.Zood <= match_vec;
    end
  end

endmodule

// File: tb/tb_check_for_zood.sv
// Directed self-checking bench for the registered slot comparator.
// Each vector is applied, one rising edge taken, and Zood sampled 1 time unit later.
// Expected masks are hand-computed constants in the vector calls.
module tb_check_for_zood;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  check_for_zood_if zif ();

  check_for_zood dut (
    .clock (clk),
    .reset (rst),
    .bus   (zif)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: Zood got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one vector, take one edge, sample just after the edge.
  task automatic apply(input string tag, input logic r, input logic c,
                       input logic [11:0] m, input logic [11:0] g,
                       input logic [3:0] exp);
    rst               = r;
    zif.check         = c;
    zif.masterPattern = m;
    zif.guess         = g;
    @(posedge clk);
    #1;
    check_val(tag, zif.Zood, exp);
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst               = 1'b1;
    zif.check         = 1'b0;
    zif.masterPattern = '0;
    zif.guess         = '0;
    @(negedge clk);

    apply("reset",          1'b1, 1'b0, 12'b000000000000, 12'b000000000000, 4'b0000);
    apply("no_check_hold",  1'b0, 1'b0, 12'b001001001001, 12'b001001001001, 4'b0000);
    apply("all_match",      1'b0, 1'b1, 12'b001001001001, 12'b001001001001, 4'b1111);
    apply("slot3_miss",     1'b0, 1'b1, 12'b011001001001, 12'b001001001001, 4'b0111);
    apply("idle_hold",      1'b0, 1'b0, 12'b011001001001, 12'b101101101101, 4'b0111);
    apply("none_match",     1'b0, 1'b1, 12'b011001001001, 12'b101101101101, 4'b0000);
    apply("no_cross_slot",  1'b0, 1'b1, 12'b000111010100, 12'b111000010100, 4'b0011);
    apply("reset_priority", 1'b1, 1'b1, 12'b010010010010, 12'b010010010010, 4'b0000);
    apply("after_reset",    1'b0, 1'b1, 12'b010010010010, 12'b010010010010, 4'b1111);
    apply("stream0",        1'b0, 1'b1, 12'b000111010100, 12'b000111010100, 4'b1111);
    apply("stream1",        1'b0, 1'b1, 12'b000111010100, 12'b000000000000, 4'b1000);
    apply("stream2",        1'b0, 1'b1, 12'b000111010100, 12'b111111010000, 4'b0110);
    apply("idle_both_move", 1'b0, 1'b0, 12'b101010101010, 12'b101010101010, 4'b0110);
    apply("slot0_miss",     1'b0, 1'b1, 12'b000000000000, 12'b000000000001, 4'b1110);
    apply("slot1_only",     1'b0, 1'b1, 12'b110101011111, 12'b001010011000, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
